// File: rtl/freq_gate_ctrl.sv
// Reciprocal (equal-precision) frequency measurement sequencer.
// The gate opens on a rising edge of sig, stays open for at least GATE_CYCLES
// clocks, and closes on the next rising edge of sig. Because both ends of the
// gate sit on sig edges, the sig count has no +/-1 edge error.
// Handshake: start is a request level sampled only in IDLE; done is a
// one-cycle pulse during which ref_count/sig_count/timeout/overflow are
// already valid, and those outputs hold until the next done pulse.
module freq_gate_ctrl #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned GATE_CYCLES    = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ref_count,
  output logic [CNT_W-1:0] sig_count,
  output logic             timeout,
  output logic             overflow
);

  // The wait counter only ever needs to hold TIMEOUT_CYCLES-1.
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W:0]    GATE_X    = (CNT_W + 1)'(GATE_CYCLES);
  localparam logic [CNT_W:0]    ONE_X     = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_CLOSE,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2, sync3;
  logic              sig_rise;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [CNT_W-1:0]  ref_cnt, ref_nxt, ref_inc;
  logic [CNT_W-1:0]  sig_cnt, sig_nxt, sig_inc;
  logic [CNT_W:0]    ref_p1;
  logic              ref_sat, sig_sat;
  logic              ovf_flag, ovf_nxt;
  logic              to_flag, to_nxt;

  assign sig_rise = sync2 & ~sync3;

  // Saturating increments; the sat flags mark an increment that was clipped.
  assign ref_sat = (ref_cnt == CNT_MAX);
  assign sig_sat = (sig_cnt == CNT_MAX);
  assign ref_inc = ref_sat ? CNT_MAX : ref_cnt + CNT_ONE;
  assign sig_inc = sig_sat ? CNT_MAX : sig_cnt + CNT_ONE;
  assign ref_p1  = {1'b0, ref_cnt} + ONE_X;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Two-flop synchronizer for sig plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // State and internal counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ref_cnt  <= '0;
      sig_cnt  <= '0;
      ovf_flag <= 1'b0;
      to_flag  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      ref_cnt  <= ref_nxt;
      sig_cnt  <= sig_nxt;
      ovf_flag <= ovf_nxt;
      to_flag  <= to_nxt;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ref_nxt   = ref_cnt;
    sig_nxt   = sig_cnt;
    ovf_nxt   = ovf_flag;
    to_nxt    = to_flag;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ARM;
          wait_nxt  = '0;
          ovf_nxt   = 1'b0;
          to_nxt    = 1'b0;
        end
      end
      S_ARM: begin
        if (sig_rise) begin
          // Opening edge: not counted, counting starts next cycle.
          state_nxt = S_MEASURE;
          ref_nxt   = '0;
          sig_nxt   = '0;
          ovf_nxt   = 1'b0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_DONE;
          to_nxt    = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_ONE;
        end
      end
      S_MEASURE: begin
        ref_nxt = ref_inc;
        if (ref_sat) ovf_nxt = 1'b1;
        if (sig_rise) begin
          sig_nxt = sig_inc;
          if (sig_sat) ovf_nxt = 1'b1;
        end
        if (sig_rise && (ref_p1 >= GATE_X)) begin
          state_nxt = S_DONE;
        end else if (ref_p1 == GATE_X) begin
          state_nxt = S_CLOSE;
          wait_nxt  = '0;
        end
      end
      S_CLOSE: begin
        ref_nxt = ref_inc;
        if (ref_sat) ovf_nxt = 1'b1;
        if (sig_rise) begin
          // Closing edge is counted.
          sig_nxt   = sig_inc;
          if (sig_sat) ovf_nxt = 1'b1;
          state_nxt = S_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_DONE;
          to_nxt    = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_ONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Result registers load on entry to DONE so they are valid with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_count <= '0;
      sig_count <= '0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
    end else if (state_nxt == S_DONE) begin
      if (to_nxt) begin
        ref_count <= '0;
        sig_count <= '0;
        timeout   <= 1'b1;
        overflow  <= 1'b0;
      end else begin
        ref_count <= ref_nxt;
        sig_count <= sig_nxt;
        timeout   <= 1'b0;
        overflow  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: three instances cover the 32-bit
// configuration and two 8-bit configurations (close near the top, saturation).
module tb_freq_gate_ctrl;

  logic clk;
  logic reset;
  logic sig;
  logic start_a, start_b, start_c;

  logic       busy_a, done_a, timeout_a, overflow_a;
  logic [31:0] ref_a, sig_a;
  logic       busy_b, done_b, timeout_b, overflow_b;
  logic [7:0] ref_b, sig_b;
  logic       busy_c, done_c, timeout_c, overflow_c;
  logic [7:0] ref_c, sig_c;

  int total;
  int bad;

  // sig generator controls
  bit sig_en;
  int sig_period;
  int ph;

  freq_gate_ctrl #(.CNT_W(32), .GATE_CYCLES(100), .TIMEOUT_CYCLES(1000)) dut_a (
    .clk(clk), .reset(reset), .sig(sig), .start(start_a),
    .busy(busy_a), .done(done_a), .ref_count(ref_a), .sig_count(sig_a),
    .timeout(timeout_a), .overflow(overflow_a)
  );

  freq_gate_ctrl #(.CNT_W(8), .GATE_CYCLES(250), .TIMEOUT_CYCLES(1000)) dut_b (
    .clk(clk), .reset(reset), .sig(sig), .start(start_b),
    .busy(busy_b), .done(done_b), .ref_count(ref_b), .sig_count(sig_b),
    .timeout(timeout_b), .overflow(overflow_b)
  );

  freq_gate_ctrl #(.CNT_W(8), .GATE_CYCLES(255), .TIMEOUT_CYCLES(1000)) dut_c (
    .clk(clk), .reset(reset), .sig(sig), .start(start_c),
    .busy(busy_c), .done(done_c), .ref_count(ref_c), .sig_count(sig_c),
    .timeout(timeout_c), .overflow(overflow_c)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // periodic sig source, high for period/2 negedges then low
  initial begin
    sig = 1'b0;
    ph  = 0;
    forever begin
      @(negedge clk);
      if (sig_en) begin
        if (ph == 0) sig = 1'b1;
        else if (ph == ((sig_period / 2) > 0 ? sig_period / 2 : 1)) sig = 1'b0;
        ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
      end else begin
        sig = 1'b0;
        ph  = 0;
      end
    end
  end

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start_a = 1'b1;
    else if (sel == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Wait (bounded) for the done pulse of the selected instance.
  task automatic wait_done(input int sel, input int budget, output bit got);
    logic d;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      if (d === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_sig(input int period);
    sig_en     = 1'b0;
    repeat (3) @(posedge clk);
    sig_period = period;
    sig_en     = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy_a, done_a, timeout_a, overflow_a} !== 4'b0) begin
      bad++; $display("FAIL reset_flags_a: got %b want 0000", {busy_a, done_a, timeout_a, overflow_a});
    end
    total++;
    if (ref_a !== 32'd0 || sig_a !== 32'd0) begin
      bad++; $display("FAIL reset_counts_a: got %0d/%0d want 0/0", ref_a, sig_a);
    end
    total++;
    if ({busy_b, done_b, busy_c, done_c} !== 4'b0 || ref_c !== 8'd0) begin
      bad++; $display("FAIL reset_bc: got %b ref_c=%0d want 0", {busy_b, done_b, busy_c, done_c}, ref_c);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_gate_close(input string name, input int period,
                                 input int exp_ref, input int exp_sig);
    bit got;
    set_sig(period);
    pulse_start(0);
    wait_done(0, 2000, got);
    total++;
    if (!got) begin
      bad++; $display("FAIL %s_done: got no done want done pulse", name);
    end
    total++;
    if (ref_a !== 32'(exp_ref) || sig_a !== 32'(exp_sig)) begin
      bad++; $display("FAIL %s_counts: got %0d/%0d want %0d/%0d", name, ref_a, sig_a, exp_ref, exp_sig);
    end
    total++;
    if (timeout_a !== 1'b0 || overflow_a !== 1'b0) begin
      bad++; $display("FAIL %s_flags: got to=%b ovf=%b want 0/0", name, timeout_a, overflow_a);
    end
    @(posedge clk);
    #1;
    total++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL %s_after: got done=%b busy=%b want 0/0", name, done_a, busy_a);
    end
  endtask

  task automatic test_timeout();
    int arm_cycles;
    bit got;
    sig_en = 1'b0;
    repeat (30) @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    arm_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_a === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy_a === 1'b1) arm_cycles++;
      @(posedge clk);
      #1;
    end
    total++;
    if (!got || arm_cycles != 1000) begin
      bad++; $display("FAIL timeout_len: got done=%b arm=%0d want 1/1000", got, arm_cycles);
    end
    total++;
    if (timeout_a !== 1'b1 || overflow_a !== 1'b0) begin
      bad++; $display("FAIL timeout_flags: got to=%b ovf=%b want 1/0", timeout_a, overflow_a);
    end
    total++;
    if (ref_a !== 32'd0 || sig_a !== 32'd0) begin
      bad++; $display("FAIL timeout_counts: got %0d/%0d want 0/0", ref_a, sig_a);
    end
    test_gate_close("after_timeout", 10, 100, 10);
  endtask

  task automatic test_cnt8();
    bit got;
    set_sig(3);
    pulse_start(1);
    wait_done(1, 2000, got);
    total++;
    if (!got || ref_b !== 8'd252 || sig_b !== 8'd84 || overflow_b !== 1'b0) begin
      bad++; $display("FAIL cnt8_close: got done=%b %0d/%0d ovf=%b want 1 252/84 ovf=0", got, ref_b, sig_b, overflow_b);
    end
    set_sig(4);
    pulse_start(2);
    wait_done(2, 2000, got);
    total++;
    if (!got || ref_c !== 8'd255 || sig_c !== 8'd64) begin
      bad++; $display("FAIL cnt8_sat_counts: got done=%b %0d/%0d want 1 255/64", got, ref_c, sig_c);
    end
    total++;
    if (overflow_c !== 1'b1 || timeout_c !== 1'b0) begin
      bad++; $display("FAIL cnt8_sat_flags: got ovf=%b to=%b want 1/0", overflow_c, timeout_c);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    set_sig(10);
    pulse_start(0);
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (busy_a !== 1'b1) begin
      bad++; $display("FAIL mid_busy: got %b want 1", busy_a);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({busy_a, done_a, timeout_a, overflow_a} !== 4'b0 || ref_a !== 32'd0 || sig_a !== 32'd0) begin
      bad++; $display("FAIL mid_reset_outputs: got %b %0d/%0d want 0000 0/0",
                      {busy_a, done_a, timeout_a, overflow_a}, ref_a, sig_a);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done_a === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL mid_reset_no_done: got %0d want 0", dones);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [31:0] r, s;
    pulse_start(0);
    repeat (40) @(posedge clk);
    pulse_start(0);
    dones = 0;
    r = '0;
    s = '0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done_a === 1'b1) begin
        dones++;
        r = ref_a;
        s = sig_a;
      end
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL start_ignored_dones: got %0d want 1", dones);
    end
    total++;
    if (r !== 32'd100 || s !== 32'd10) begin
      bad++; $display("FAIL start_ignored_counts: got %0d/%0d want 100/10", r, s);
    end
  endtask

  task automatic test_back_to_back();
    int stable_bad;
    bit got;
    logic [31:0] r_hold, s_hold;
    stable_bad = 0;
    r_hold = ref_a;
    s_hold = sig_a;
    @(negedge clk);
    start_a = 1'b1;
    for (int n = 0; n < 3; n++) begin
      got = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(posedge clk);
        #1;
        if (done_a === 1'b1) begin
          got = 1'b1;
          break;
        end
        if (n > 0 && (ref_a !== r_hold || sig_a !== s_hold)) stable_bad++;
      end
      total++;
      if (!got || ref_a !== 32'd100 || sig_a !== 32'd10) begin
        bad++; $display("FAIL b2b_%0d_counts: got done=%b %0d/%0d want 1 100/10", n, got, ref_a, sig_a);
      end
      r_hold = ref_a;
      s_hold = sig_a;
      @(posedge clk);
      #1;
      total++;
      if (busy_a !== 1'b0) begin
        bad++; $display("FAIL b2b_%0d_idle: got busy=%b want 0", n, busy_a);
      end
      @(posedge clk);
      #1;
      total++;
      if (busy_a !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d_rearm: got busy=%b want 1", n, busy_a);
      end
    end
    start_a = 1'b0;
    total++;
    if (stable_bad != 0) begin
      bad++; $display("FAIL b2b_stable: got %0d changes want 0", stable_bad);
    end
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (busy_a === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL b2b_drain: got busy=1 want 0");
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    start_c    = 1'b0;
    sig_en     = 1'b0;
    sig_period = 10;
    test_reset();
    test_gate_close("period10", 10, 100, 10);
    test_gate_close("period7", 7, 105, 15);
    test_timeout();
    test_cnt8();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
